niosii_tutorial_irq_ctrl: RTL and testbench
===========================================

Name: niosii_tutorial_irq_ctrl

Overview:
Interrupt aggregator that sits directly downstream of the system-clock timer and other Avalon-MM peripherals. It collects up to N_IRQ interrupt request lines, synchronises and latches them as level- or edge-sensitive per source, and applies a per-source enable mask. It drives one combined interrupt line to the Nios II core. Software reads a priority-encoded vector over a 16-bit Avalon-MM slave with the same register timing as the timer.

Parameters:
N_IRQ, 8, number of interrupt sources (1..15); bits at and above N_IRQ read as 0 and ignore writes
SYNC_STAGES, 2, synchroniser flops per source (>=2)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
irq_src  input  N_IRQ  raw interrupt requests (e.g. bit 0 = timer irq)
address  input  3  word address
chipselect  input  1  slave select
write_n  input  1  active-low write
writedata  input  16  write data
readdata  output  16  registered read data
irq_out  output  1  combined interrupt to CPU

Behaviour:
- Reset: readdata=0, irq_out=0, pending=0, enable=0, edge_sel=0 (all sources level), sync chains=0, prev=0. Reset is asynchronous and takes effect immediately, including mid-operation.
- Write strobe: chipselect && ~write_n && address==A. Writes take effect at that clock edge.
- Register map:
  - 0 PENDING: R = pending; W = write-1-to-clear, edge sources only.
  - 1 ENABLE: R/W.
  - 2 EDGE_SEL: R/W; 1 = rising-edge source, 0 = level source.
  - 3 VECTOR: R only; bit15 = valid, bits[3:0] = lowest index with pending&enable set; value 0x0000 when none.
  - 4 FORCE: W sets pending for edge sources; bits for level sources are ignored; reads 0.
  - 5-7: read 0; writes ignored.
- Read path: readdata <= read_mux every clock, independent of chipselect. Read latency is 1 cycle.
- Synchronisation: each irq_src bit passes through SYNC_STAGES flops to give s. prev <= s every cycle.
- Level source: pending[i] <= s[i] every cycle. W1C and FORCE have no effect.
- Edge source:
  - Set on s[i] & ~prev[i], or on a FORCE bit.
  - Clear on W1C bit.
  - If set and clear occur in the same cycle, set wins.
  - Otherwise pending holds.
- EDGE_SEL write: every bit whose value changes clears pending[i] in the same cycle. Edge detection on the next cycle uses the current prev.
- irq_out <= |(pending & enable), registered.
  - Latency from a sampled irq_src level to irq_out is SYNC_STAGES+2 clocks.
  - Latency from a W1C/ENABLE write to irq_out is 2 clocks.
- VECTOR is a combinational priority encode of pending&enable, registered through readdata. Lowest index has highest priority.
- A 1-cycle synchronous pulse on an edge source is captured. A 1-cycle pulse on a level source produces 1 cycle of pending.

Decomposition:
- Shared package: register address constants (ADDR_PENDING=0, ADDR_ENABLE=1, ADDR_EDGE_SEL=2, ADDR_VECTOR=3, ADDR_FORCE=4) and VECTOR_VALID_BIT=15.
- One sub-module, niosii_tutorial_irq_sync: a single-bit SYNC_STAGES-deep synchroniser with async reset, instantiated N_IRQ times via generate.
- Priority encoder stays inline as a function.

Test Plan:
1. Level path: ENABLE=0x0001, irq_src[0] 0->1. Required: irq_out=1 exactly 4 clocks after first sampling edge; VECTOR reads 0x8000; irq_src[0]->0 drops irq_out 4 clocks later.
2. Edge latch/W1C: EDGE_SEL=0x0004, ENABLE=0x0004, 1-cycle pulse on irq_src[2]. Required: PENDING reads 0x0004 and stays. Write 0x0004 to addr 0: PENDING=0 next cycle and irq_out=0 two clocks after the write.
3. Priority/mask: level sources 3 and 5 high, ENABLE=0x00FF. Required: VECTOR reads 0x8003. ENABLE=0x00F7: VECTOR reads 0x8005. ENABLE=0: VECTOR reads 0x0000 and irq_out falls.
4. Set/clear collision: edge source 1 pending; new rising edge of s[1] in the same cycle as W1C 0x0002. Required: PENDING bit1 remains 1.
5. FORCE: EDGE_SEL=0x0010, write 0x0011 to addr 4. Required: PENDING=0x0010 (bit0 is level, ignored). Toggling EDGE_SEL bit4 to 0 clears bit4.
6. Reset mid-operation: with PENDING=0x0014 and irq_out=1, pulse reset_n low between clocks. Required: irq_out, readdata, and all registers are 0 immediately. No spurious edge is latched after release while irq_src is held high on an edge source.

Source files
------------

// File: rtl/niosii_tutorial_irq_ctrl_pkg.sv
//------------------------------------------------------------------------------
// niosii_tutorial_irq_ctrl_pkg : register map shared by the IRQ aggregator
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package niosii_tutorial_irq_ctrl_pkg;

  localparam logic [2:0] ADDR_PENDING  = 3'd0;
  localparam logic [2:0] ADDR_ENABLE   = 3'd1;
  localparam logic [2:0] ADDR_EDGE_SEL = 3'd2;
  localparam logic [2:0] ADDR_VECTOR   = 3'd3;
  localparam logic [2:0] ADDR_FORCE    = 3'd4;

  localparam int VECTOR_VALID_BIT = 15;

endpackage

`default_nettype wire

// File: rtl/niosii_tutorial_irq_sync.sv
//------------------------------------------------------------------------------
// niosii_tutorial_irq_sync : single-bit multi-flop synchroniser, async reset
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module niosii_tutorial_irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d};
    end
  end

  assign q = r_chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/niosii_tutorial_irq_ctrl.sv
//------------------------------------------------------------------------------
// niosii_tutorial_irq_ctrl : level/edge interrupt aggregator with Avalon-MM slave
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module niosii_tutorial_irq_ctrl
  import niosii_tutorial_irq_ctrl_pkg::*;
#(
  parameter int N_IRQ       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_IRQ-1:0] irq_src,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [15:0]      writedata,
  output logic [15:0]      readdata,
  output logic             irq_out
);

  logic [N_IRQ-1:0] w_s;
  logic [N_IRQ-1:0] r_prev;
  logic [N_IRQ-1:0] r_pending;
  logic [N_IRQ-1:0] r_enable;
  logic [N_IRQ-1:0] r_edge_sel;

  logic             w_wr;
  logic [N_IRQ-1:0] w_wdata;
  logic [N_IRQ-1:0] w_rise;
  logic [N_IRQ-1:0] w_force;
  logic [N_IRQ-1:0] w_w1c;
  logic [N_IRQ-1:0] w_sel_changed;
  logic [N_IRQ-1:0] w_edge_nxt;
  logic [N_IRQ-1:0] w_pending_nxt;
  logic [N_IRQ-1:0] w_active;
  logic [15:0]      w_read_mux;

  // Write data bits above N_IRQ have no backing storage.
  logic unused_wdata_hi;
  assign unused_wdata_hi = ^writedata[15:N_IRQ];

  function automatic logic [15:0] prio_vector(input logic [N_IRQ-1:0] req);
    logic [15:0] v;
    v = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        v                   = '0;
        v[VECTOR_VALID_BIT] = 1'b1;
        v[3:0]              = 4'(i);
      end
    end
    return v;
  endfunction

  generate
    for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_sync
      niosii_tutorial_irq_sync #(
        .STAGES (SYNC_STAGES)
      ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (irq_src[gi]),
        .q       (w_s[gi])
      );
    end
  endgenerate

  assign w_wr    = chipselect && !write_n;
  assign w_wdata = writedata[N_IRQ-1:0];
  assign w_rise  = w_s & ~r_prev;
  assign w_force = (w_wr && address == ADDR_FORCE)   ? (w_wdata & r_edge_sel) : '0;
  assign w_w1c   = (w_wr && address == ADDR_PENDING) ? w_wdata : '0;
  assign w_sel_changed = (w_wr && address == ADDR_EDGE_SEL) ? (w_wdata ^ r_edge_sel) : '0;

  // Set beats clear on edge sources; a changed EDGE_SEL bit overrides everything.
  assign w_edge_nxt    = w_rise | w_force | (r_pending & ~w_w1c);
  assign w_pending_nxt = ((r_edge_sel & w_edge_nxt) | (~r_edge_sel & w_s)) & ~w_sel_changed;
  assign w_active      = r_pending & r_enable;

  always_comb begin
    w_read_mux = '0;
    case (address)
      ADDR_PENDING:  w_read_mux = 16'(r_pending);
      ADDR_ENABLE:   w_read_mux = 16'(r_enable);
      ADDR_EDGE_SEL: w_read_mux = 16'(r_edge_sel);
      ADDR_VECTOR:   w_read_mux = prio_vector(w_active);
      default:       w_read_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev     <= '0;
      r_pending  <= '0;
      r_enable   <= '0;
      r_edge_sel <= '0;
      readdata   <= '0;
      irq_out    <= 1'b0;
    end else begin
      r_prev    <= w_s;
      r_pending <= w_pending_nxt;
      readdata  <= w_read_mux;
      irq_out   <= |w_active;
      if (w_wr && address == ADDR_ENABLE) begin
        r_enable <= w_wdata;
      end
      if (w_wr && address == ADDR_EDGE_SEL) begin
        r_edge_sel <= w_wdata;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_niosii_tutorial_irq_ctrl.sv
//------------------------------------------------------------------------------
// tb_niosii_tutorial_irq_ctrl : directed self-checking bench for the IRQ aggregator
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_niosii_tutorial_irq_ctrl;

  logic        clk;
  logic        reset_n;
  logic [7:0]  irq_src;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq_out;

  int tests_run;
  int tests_failed;

  niosii_tutorial_irq_ctrl #(
    .N_IRQ       (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .irq_src    (irq_src),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_out    (irq_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Strobe lands on the next rising edge; returns at the following falling edge.
  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(negedge clk);
    d          = readdata;
    chipselect = 1'b0;
  endtask

  logic [15:0] rv;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    irq_src      = '0;
    address      = '0;
    chipselect   = 1'b0;
    write_n      = 1'b1;
    writedata    = '0;
    cycles(2);
    check("reset_readdata", readdata, 16'h0000);
    check("reset_irq_out", {15'd0, irq_out}, 16'h0000);
    reset_n = 1'b1;
    cycles(1);

    // 1. level path latency
    wr(3'd1, 16'h0001);
    irq_src[0] = 1'b1;
    cycles(3);
    check("lvl_irq_before", {15'd0, irq_out}, 16'h0000);
    cycles(1);
    check("lvl_irq_at4", {15'd0, irq_out}, 16'h0001);
    rd(3'd3, rv);
    check("lvl_vector", rv, 16'h8000);
    irq_src[0] = 1'b0;
    cycles(3);
    check("lvl_fall_before", {15'd0, irq_out}, 16'h0001);
    cycles(1);
    check("lvl_fall_at4", {15'd0, irq_out}, 16'h0000);

    // 2. edge latch and W1C
    wr(3'd2, 16'h0004);
    wr(3'd1, 16'h0004);
    irq_src[2] = 1'b1;
    cycles(1);
    irq_src[2] = 1'b0;
    cycles(5);
    rd(3'd0, rv);
    check("edge_pending", rv, 16'h0004);
    cycles(3);
    rd(3'd0, rv);
    check("edge_pending_hold", rv, 16'h0004);
    check("edge_irq", {15'd0, irq_out}, 16'h0001);
    wr(3'd0, 16'h0004);
    check("w1c_irq_1clk", {15'd0, irq_out}, 16'h0001);
    rd(3'd0, rv);
    check("w1c_pending", rv, 16'h0000);
    check("w1c_irq_2clk", {15'd0, irq_out}, 16'h0000);

    // 3. priority and mask
    wr(3'd2, 16'h0000);
    irq_src = 8'h28;
    wr(3'd1, 16'h00FF);
    cycles(4);
    rd(3'd3, rv);
    check("prio_vec_3", rv, 16'h8003);
    check("prio_irq", {15'd0, irq_out}, 16'h0001);
    wr(3'd1, 16'h00F7);
    rd(3'd3, rv);
    check("prio_vec_5", rv, 16'h8005);
    wr(3'd1, 16'h0000);
    rd(3'd3, rv);
    check("prio_vec_none", rv, 16'h0000);
    check("prio_irq_fall", {15'd0, irq_out}, 16'h0000);
    rd(3'd5, rv);
    check("addr5_reads0", rv, 16'h0000);

    // 4. set/clear collision on edge source 1
    irq_src = '0;
    cycles(4);
    wr(3'd2, 16'h0002);
    wr(3'd1, 16'h0002);
    irq_src[1] = 1'b1;
    cycles(1);
    irq_src[1] = 1'b0;
    cycles(5);
    rd(3'd0, rv);
    check("coll_pre_pending", rv, 16'h0002);
    irq_src[1] = 1'b1;
    cycles(1);
    irq_src[1] = 1'b0;
    cycles(1);
    wr(3'd0, 16'h0002);
    rd(3'd0, rv);
    check("coll_set_wins", rv, 16'h0002);
    cycles(3);
    wr(3'd0, 16'h0002);
    rd(3'd0, rv);
    check("coll_plain_w1c", rv, 16'h0000);

    // 5. FORCE
    wr(3'd2, 16'h0010);
    wr(3'd4, 16'h0011);
    rd(3'd0, rv);
    check("force_pending", rv, 16'h0010);
    rd(3'd4, rv);
    check("force_reads0", rv, 16'h0000);
    wr(3'd2, 16'h0000);
    rd(3'd0, rv);
    check("edgesel_toggle_clr", rv, 16'h0000);

    // 6. asynchronous reset mid-operation
    wr(3'd2, 16'h0014);
    wr(3'd4, 16'h0014);
    wr(3'd1, 16'h0014);
    rd(3'd0, rv);
    check("pre_rst_pending", rv, 16'h0014);
    check("pre_rst_irq", {15'd0, irq_out}, 16'h0001);
    irq_src[2] = 1'b1;
    cycles(4);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_irq", {15'd0, irq_out}, 16'h0000);
    check("rst_async_rdata", readdata, 16'h0000);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    rd(3'd0, rv);
    check("rst_pending", rv, 16'h0000);
    rd(3'd1, rv);
    check("rst_enable", rv, 16'h0000);
    rd(3'd2, rv);
    check("rst_edge_sel", rv, 16'h0000);
    cycles(4);
    rd(3'd0, rv);
    check("post_rst_level_follow", rv, 16'h0004);
    wr(3'd2, 16'h0004);
    cycles(3);
    rd(3'd0, rv);
    check("no_spurious_edge", rv, 16'h0000);
    check("post_rst_irq", {15'd0, irq_out}, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
